sqrt_arbiter: RTL and testbench

//  Shares one iterative sqrt unit among NREQ requesters. Round-robin arbiter and sequencer:

---
 rtl/sqrt_arbiter.sv | 150 +++++++++++++++
 tb/tb_sqrt_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter and sequencer that shares one iterative sqrt unit among NREQ clients.
// One operation is in flight at a time; negative operands are answered without using the unit.
module sqrt_arbiter #(
    parameter int NREQ = 4,
    parameter int IL   = 8,
    parameter int FL   = 12
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*(IL+FL)-1:0]   req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic [NREQ-1:0]           rsp_valid,
    input  logic [NREQ-1:0]           rsp_ready,
    output logic [IL+FL-1:0]          rsp_data,
    output logic                      rsp_err,
    output logic [2:0]                grant_id,
    output logic                      busy,
    output logic [IL+FL-1:0]          sq_in,
    output logic                      sq_input_ready,
    output logic                      sq_output_taken,
    input  logic [IL+FL-1:0]          sq_out,
    input  logic [1:0]                sq_state
);
    localparam int W  = IL + FL;
    localparam int HW = W / 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_TAKE  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t          state_reg, state_next;
    logic [2:0]      rr_ptr_reg;
    logic [2:0]      grant_id_reg;
    logic [W-1:0]    rsp_data_reg;
    logic            rsp_err_reg;
    logic [W-1:0]    sq_in_reg;

    logic            grant_found;
    logic [2:0]      grant_idx;
    logic [2:0]      rr_next;
    logic [W-1:0]    op_sel;
    logic            op_neg;
    logic            rsp_taken;
    logic            unused_sq_hi;

    // The request vector is doubled so a search starting at rr_ptr wraps naturally;
    // the first set bit at or above rr_ptr is always within NREQ positions of it.
    logic [2*NREQ-1:0] req_dbl;
    logic [3:0]        pick_j [2*NREQ+1];

    assign req_dbl            = {req_valid, req_valid};
    assign pick_j[2*NREQ]     = 4'd0;
    assign grant_found        = |req_valid;

    generate
        for (genvar gi = 0; gi < 2*NREQ; gi++) begin : g_pick
            assign pick_j[gi] = (req_dbl[gi] && (4'(gi) >= {1'b0, rr_ptr_reg})) ? 4'(gi) : pick_j[gi+1];
        end
    endgenerate

    assign grant_idx = (pick_j[0] >= 4'(NREQ)) ? 3'(pick_j[0] - 4'(NREQ)) : pick_j[0][2:0];
    assign rr_next   = (grant_idx == 3'(NREQ-1)) ? 3'd0 : grant_idx + 3'd1;

    // One-hot operand mux keyed on the winning index.
    logic [W-1:0] op_chain [NREQ+1];
    assign op_chain[0] = '0;
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_opmux
            assign op_chain[gi+1] = op_chain[gi] | ({W{grant_idx == 3'(gi)}} & req_data[gi*W +: W]);
        end
    endgenerate
    assign op_sel = op_chain[NREQ];
    assign op_neg = op_sel[W-1];

    assign rsp_taken    = |(rsp_valid & rsp_ready);
    assign unused_sq_hi = ^sq_out[W-1:HW];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (grant_found) state_next = op_neg ? S_RESP : S_ISSUE;
            S_ISSUE: if (sq_state == 2'b00) state_next = S_WAIT;
            S_WAIT:  if (sq_state == 2'b10) state_next = S_TAKE;
            S_TAKE:  state_next = S_RESP;
            S_RESP:  if (rsp_taken) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready       = '0;
        rsp_valid       = '0;
        sq_input_ready  = 1'b0;
        sq_output_taken = 1'b0;
        busy            = (state_reg != S_IDLE);
        case (state_reg)
            S_IDLE:  if (grant_found && !reset) req_ready = NREQ'(1) << grant_idx;
            S_ISSUE: sq_input_ready = (sq_state == 2'b00);
            S_TAKE:  sq_output_taken = 1'b1;
            S_RESP:  rsp_valid = NREQ'(1) << grant_id_reg;
            default: ;
        endcase
    end

    // Operand, grant and response registers; sq_in only changes at a grant, so it is
    // stable for the whole ISSUE/WAIT window.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_reg   <= 3'd0;
            grant_id_reg <= 3'd0;
            rsp_data_reg <= '0;
            rsp_err_reg  <= 1'b0;
            sq_in_reg    <= '0;
        end else begin
            if (state_reg == S_IDLE && grant_found) begin
                grant_id_reg <= grant_idx;
                rr_ptr_reg   <= rr_next;
                if (op_neg) begin
                    rsp_data_reg <= '0;
                    rsp_err_reg  <= 1'b1;
                end else begin
                    sq_in_reg    <= op_sel;
                    rsp_err_reg  <= 1'b0;
                end
            end
            if (state_reg == S_TAKE) begin
                rsp_data_reg <= {{(W-HW){1'b0}}, sq_out[HW-1:0]};
            end
        end
    end

    assign rsp_data = rsp_data_reg;
    assign rsp_err  = rsp_err_reg;
    assign grant_id = grant_id_reg;
    assign sq_in    = sq_in_reg;

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Bench for sqrt_arbiter: behavioural sqrt-unit stub, transaction-level scoreboard,
// a table of single-request vectors, directed multi-cycle sequences and random traffic.
module tb_sqrt_arbiter;
    localparam int NREQ = 4;
    localparam int IL   = 8;
    localparam int FL   = 12;
    localparam int W    = IL + FL;
    localparam int HW   = W / 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [W-1:0]      rsp_data;
    logic              rsp_err;
    logic [2:0]        grant_id;
    logic              busy;
    logic [W-1:0]      sq_in;
    logic              sq_input_ready;
    logic              sq_output_taken;
    logic [W-1:0]      sq_out;
    logic [1:0]        sq_state;

    logic [W-1:0]      tb_op [NREQ];

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_pack
            assign req_data[gi*W +: W] = tb_op[gi];
        end
    endgenerate

    sqrt_arbiter #(.NREQ(NREQ), .IL(IL), .FL(FL)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .grant_id(grant_id), .busy(busy),
        .sq_in(sq_in), .sq_input_ready(sq_input_ready), .sq_output_taken(sq_output_taken),
        .sq_out(sq_out), .sq_state(sq_state)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int isqrt(input int x);
        int r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    // Sqrt unit stub: result in the low half, junk in the high half; optional busy
    // cool-down after a result is taken so the arbiter has to hold in its issue phase.
    logic [W-1:0] u_op;
    int           u_cnt;
    logic         u_cool;
    int           lat_lo = 1;
    int           lat_hi = 3;
    bit           cool_en = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            sq_state <= 2'b00;
            sq_out   <= '0;
            u_cnt    <= 0;
            u_cool   <= 1'b0;
        end else begin
            case (sq_state)
                2'b00: if (sq_input_ready) begin
                    u_op     <= sq_in;
                    u_cnt    <= int'($urandom_range(lat_hi, lat_lo));
                    sq_state <= 2'b01;
                end
                2'b01: if (u_cnt > 1) u_cnt <= u_cnt - 1;
                       else if (u_cool) begin u_cool <= 1'b0; sq_state <= 2'b00; end
                       else begin
                           sq_state <= 2'b10;
                           sq_out   <= {HW'($urandom), HW'(isqrt(int'(u_op)))};
                       end
                2'b10: if (sq_output_taken) begin
                    sq_out <= '0;
                    if (cool_en && $urandom_range(1, 0) == 1) begin
                        u_cool   <= 1'b1;
                        u_cnt    <= int'($urandom_range(5, 1));
                        sq_state <= 2'b01;
                    end else begin
                        sq_state <= 2'b00;
                    end
                end
                default: sq_state <= 2'b00;
            endcase
        end
    end

    // Scoreboard: round-robin pointer, one outstanding op, expected strobes and response.
    bit           outstanding = 1'b0;
    bit           cur_neg = 1'b0;
    bit           issued = 1'b0;
    int           out_id = 0;
    int           since = 0;
    int           ready_age = -1;
    int           model_rr = 0;
    int           ops_done = 0;
    int           issue_cnt = 0;
    logic [W-1:0] cur_op = '0;
    logic [W-1:0] exp_data = '0;
    int           acc_count [NREQ];
    bit           acc_flag [NREQ];
    int           waits [NREQ];

    always @(negedge clk) begin
        int              exp_g;
        int              dut_g;
        logic [NREQ-1:0] exp_rdy;
        logic [NREQ-1:0] exp_rsp;
        logic            exp_issue;
        logic            exp_take;
        if (sq_input_ready) issue_cnt++;
        if (reset) begin
            outstanding = 1'b0;
            model_rr    = 0;
            issued      = 1'b0;
            ready_age   = -1;
            since       = 0;
            for (int i = 0; i < NREQ; i++) waits[i] = 0;
        end else begin
            if (outstanding) begin
                since++;
                if (ready_age >= 0) ready_age++;
            end
            exp_g = -1;
            for (int k = NREQ - 1; k >= 0; k--)
                if (req_valid[(model_rr + k) % NREQ]) exp_g = (model_rr + k) % NREQ;
            exp_rdy   = (!outstanding && exp_g >= 0) ? (NREQ'(1) << exp_g) : '0;
            exp_issue = outstanding && !cur_neg && !issued && since >= 1 && sq_state == 2'b00;
            exp_take  = outstanding && ready_age == 1;
            exp_rsp   = (outstanding && ((cur_neg && since >= 1) || (!cur_neg && ready_age >= 2)))
                        ? (NREQ'(1) << out_id) : '0;

            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("busy", 32'(busy), 32'(outstanding));
            chk("sq_input_ready", 32'(sq_input_ready), 32'(exp_issue));
            chk("sq_output_taken", 32'(sq_output_taken), 32'(exp_take));
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
            if (exp_issue) begin
                chk("sq_in", 32'(sq_in), 32'(cur_op));
                issued = 1'b1;
            end
            if (exp_rsp != '0) begin
                chk("rsp_data", 32'(rsp_data), 32'(exp_data));
                chk("rsp_err", 32'(rsp_err), 32'(cur_neg));
                chk("grant_id", 32'(grant_id), 32'(out_id));
                if (rsp_ready[out_id]) begin
                    outstanding = 1'b0;
                    ops_done++;
                end
            end
            if (outstanding && issued && ready_age < 0 && sq_state == 2'b10) ready_age = 0;

            if (req_ready != '0) begin
                dut_g = 0;
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) dut_g = i;
                acc_flag[dut_g] = 1'b1;
                acc_count[dut_g]++;
                for (int i = 0; i < NREQ; i++) begin
                    if (i == dut_g || !req_valid[i]) waits[i] = 0;
                    else begin
                        waits[i]++;
                        chk("starvation_bound", 32'(waits[i] <= NREQ - 1), 32'd1);
                    end
                end
            end
            if (exp_rdy != '0) begin
                cur_op      = tb_op[exp_g];
                cur_neg     = cur_op[W-1];
                exp_data    = cur_neg ? '0 : W'(isqrt(int'(cur_op)));
                out_id      = exp_g;
                outstanding = 1'b1;
                since       = 0;
                issued      = 1'b0;
                ready_age   = -1;
                model_rr    = (exp_g + 1) % NREQ;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; req_valid = '0; rsp_ready = '0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sq_in", 32'(sq_in), 32'd0);
        chk("rst_sq_input_ready", 32'(sq_input_ready), 32'd0);
        chk("rst_sq_output_taken", 32'(sq_output_taken), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic run_single(input int r, input logic [W-1:0] d, input int hold,
                              output logic [W-1:0] data, output logic err, output int issues);
        int n;
        int i0;
        @(posedge clk); #1;
        i0 = issue_cnt;
        tb_op[r]  = d;
        req_valid = NREQ'(1) << r;
        rsp_ready = (hold > 0) ? '0 : '1;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready[r] && n < 50);
        chk("accept_seen", 32'(req_ready[r]), 32'd1);
        @(posedge clk); #1;
        req_valid = '0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid[r] && n < 100);
        chk("rsp_seen", 32'(rsp_valid[r]), 32'd1);
        data = rsp_data;
        err  = rsp_err;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 32'(NREQ'(1) << r));
            chk("hold_data", 32'(rsp_data), 32'(data));
        end
        if (hold > 0) begin
            @(posedge clk); #1;
            rsp_ready = '1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        issues = issue_cnt - i0;
    endtask

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(7, 0))
            0:       return {1'b1, (W-1)'($urandom)};
            1:       return W'(524287);
            2:       return '0;
            3:       return W'($urandom_range(300, 0));
            default: return W'($urandom_range(524287, 0));
        endcase
    endfunction

    typedef struct {
        int           req;
        logic [W-1:0] data;
        int           hold;
        logic [W-1:0] exp;
        logic         err;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] d;
        logic         e;
        int           iss;
        int           n;
        int           exp_res [4];

        req_valid = '0;
        rsp_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            tb_op[i] = '0; acc_count[i] = 0; acc_flag[i] = 1'b0; waits[i] = 0;
        end

        vecs[0] = '{0, W'(144),     0, W'(12),  1'b0};
        vecs[1] = '{1, W'(1000),    5, W'(31),  1'b0};
        vecs[2] = '{2, W'('h80000), 0, W'(0),   1'b1};
        vecs[3] = '{3, W'(524287),  0, W'(724), 1'b0};
        vecs[4] = '{0, W'(0),       0, W'(0),   1'b0};
        vecs[5] = '{1, W'(1),       2, W'(1),   1'b0};
        vecs[6] = '{2, W'(3),       0, W'(1),   1'b0};
        vecs[7] = '{3, W'('hFFFFF), 1, W'(0),   1'b1};
        vecs[8] = '{0, W'(65025),   0, W'(255), 1'b0};
        vecs[9] = '{1, W'(65024),   0, W'(254), 1'b0};

        do_reset();

        foreach (vecs[v]) begin
            run_single(vecs[v].req, vecs[v].data, vecs[v].hold, d, e, iss);
            chk("vec_data", 32'(d), 32'(vecs[v].exp));
            chk("vec_err", 32'(e), 32'(vecs[v].err));
            chk("vec_issue_count", 32'(iss), vecs[v].err ? 32'd0 : 32'd1);
            $display("vec %0d: req%0d op=%0d -> data=%0d err=%0d issues=%0d", v, vecs[v].req,
                     vecs[v].data, d, e, iss);
        end

        // All four requesters at once from a fresh pointer: grants must go 0,1,2,3.
        do_reset();
        exp_res = '{2, 3, 4, 5};
        tb_op[0] = W'(4); tb_op[1] = W'(9); tb_op[2] = W'(16); tb_op[3] = W'(25);
        @(posedge clk); #1;
        rsp_ready = '1;
        req_valid = '1;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (req_ready == '0 && n < 60);
            chk("grant_order", 32'(req_ready), 32'(NREQ'(1) << g));
            @(posedge clk); #1;
            req_valid = req_valid & ~(NREQ'(1) << g);
            n = 0;
            do begin @(negedge clk); n++; end while (rsp_valid == '0 && n < 60);
            chk("all4_data", 32'(rsp_data), 32'(exp_res[g]));
            $display("all4: grant %0d -> data=%0d", g, rsp_data);
        end
        @(posedge clk); #1;

        // Reset while the unit is computing; the aborted op must never respond.
        lat_lo = 8; lat_hi = 8;
        tb_op[3] = W'(100000);
        req_valid = NREQ'(1) << 3;
        n = 0;
        do begin @(negedge clk); n++; end while (!(busy && sq_state == 2'b01) && n < 30);
        chk("reached_wait", 32'(busy && sq_state == 2'b01), 32'd1);
        do_reset();
        lat_lo = 1; lat_hi = 3;
        run_single(0, W'(64), 0, d, e, iss);
        chk("after_reset_data", 32'(d), 32'd8);
        chk("after_reset_err", 32'(e), 32'd0);
        $display("after reset: op=64 -> data=%0d err=%0d", d, e);

        // Random traffic on all requesters with random response back-pressure.
        cool_en = 1'b1; lat_lo = 1; lat_hi = 6;
        ops_done = 0;
        for (int i = 0; i < NREQ; i++) begin acc_count[i] = 0; acc_flag[i] = 1'b0; end
        for (int cyc = 0; cyc < 40000 && ops_done < 1000; cyc++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++) begin
                if (acc_flag[i]) begin
                    acc_flag[i] = 1'b0;
                    if ($urandom_range(1, 0) == 1) tb_op[i] = rand_op();
                    else req_valid[i] = 1'b0;
                end else if (!req_valid[i] && $urandom_range(3, 0) == 0) begin
                    tb_op[i]     = rand_op();
                    req_valid[i] = 1'b1;
                end
            end
            rsp_ready = NREQ'($urandom);
        end
        chk("random_ops_done", 32'(ops_done >= 1000), 32'd1);
        for (int i = 0; i < NREQ; i++) chk("requester_served", 32'(acc_count[i] > 0), 32'd1);
        $display("random: ops=%0d grants=%0d/%0d/%0d/%0d", ops_done, acc_count[0], acc_count[1],
                 acc_count[2], acc_count[3]);
        req_valid = '0;
        rsp_ready = '1;
        repeat (40) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
